mac_accum_stage: RTL and testbench
==================================

MAC_ACCUM_STAGE -- requirements
Module: mac_accum_stage

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16, the width of a signed two's-complement fixed-point operand.
REQ-002 SHALL have parameter FRAC_BITS, default 8, the number of fractional bits in each operand and in the result.
REQ-003 SHALL have parameter GUARD_BITS, default 4, the extra accumulator headroom bits; ACC_SIZE = 2*DATA_SIZE+GUARD_BITS.
REQ-004 SHALL have port clk, input, 1 bit; the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit; asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit; marks an operand pair as valid (the pair comes from the multiply buffer).
REQ-007 SHALL have port in_a, input, DATA_SIZE bits; the vector operand (mul_buffer_out1).
REQ-008 SHALL have port in_b, input, DATA_SIZE bits; the matrix operand (mul_buffer_out2).
REQ-009 SHALL have port row_last, input, 1 bit; qualified by in_valid; marks the last pair of the current row.
REQ-010 SHALL have port flush, input, 1 bit; synchronous discard of all in-flight work.
REQ-011 SHALL have port result, output, DATA_SIZE bits; the row dot product.
REQ-012 SHALL have port result_valid, output, 1 bit; a one-cycle pulse that qualifies result.
REQ-013 SHALL have port busy, output, 1 bit; high while any partial row or pipeline entry exists.
REQ-014 SHALL have port overflow, output, 1 bit; sticky, set when a result exceeds the DATA_SIZE range.

Function
REQ-015 SHALL register the full-width signed product in_a*in_b (2*DATA_SIZE bits) in stage 1 when in_valid is high.
REQ-016 SHALL add the stage-1 product into the ACC_SIZE signed accumulator in stage 2.
REQ-017 SHALL, on a row_last pair, form result = (acc + product) >>> FRAC_BITS (arithmetic shift) and assert result_valid exactly 2 cycles after the row_last input cycle.
REQ-018 SHALL clear the accumulator in the same cycle result is produced, so back-to-back rows run with zero bubbles.
REQ-019 SHALL implement FSM states IDLE (accumulator empty) and ACCUM (partial row held): IDLE->ACCUM on a valid non-last pair; ACCUM->IDLE on a row_last pair or on flush.
REQ-020 SHALL treat a single-pair row (row_last on the first pair) as a complete row and remain in IDLE.
REQ-021 SHALL tolerate in_valid gaps of any length mid-row without changing the accumulator.
REQ-022 SHALL, on flush, clear the stage-1 register, the accumulator and the FSM; it SHALL NOT emit result_valid for dropped work, and overflow SHALL be preserved.
REQ-023 SHALL give flush priority when flush and in_valid occur in the same cycle: the pair is dropped.
REQ-024 SHALL drive busy = (state==ACCUM) | stage-1 valid | stage-2 valid.

Reset
REQ-025 SHALL, while rst=0, force result=0, result_valid=0, busy=0, overflow=0, accumulator=0, stage-1 valid=0 and state=IDLE, independently of clk.
REQ-026 SHALL, on reset mid-row, discard the partial row; the first row after reset deassertion SHALL start from zero.

Configuration
REQ-027 SHALL, with MAC_SATURATE_EN defined, clamp an out-of-range shifted result to 0x7FFF / 0x8000 (for DATA_SIZE=16) and set overflow.
REQ-028 SHALL, without MAC_SATURATE_EN, truncate the result to the low DATA_SIZE bits (wrap-around), still set overflow on out-of-range, and contain no clamp logic.

Structure
REQ-029 SHALL take the default DATA_SIZE, FRAC_BITS and GUARD_BITS constants from shared package euler_pkg, which the fetch and buffer stages also use.
REQ-030 SHALL place the registered signed multiplier in sub-module fixed_mul; the accumulate, FSM and output logic SHALL stay in mac_accum_stage.

Verification (DATA_SIZE=16, FRAC_BITS=8)
REQ-031 SHALL check a 3-pair row: (0x0100,0x0200), (0x0080,0x0100), (0x0100,0xFF00), last pair at cycle T -> result=0x0180 with result_valid at T+2 only.
REQ-032 SHALL check back-to-back rows: row1 = {(0x0100,0x0100)} last, then row2 = {(0x0200,0x0100)} last on the next cycle -> results 0x0100 and 0x0200 on consecutive cycles.
REQ-033 SHALL check overflow on a single pair (0x7F00,0x7F00) last: with MAC_SATURATE_EN -> result=0x7FFF and overflow=1; without it -> result=0x0100 and overflow=1.
REQ-034 SHALL check flush: two non-last pairs, then flush together with a valid pair -> no result_valid and busy=0 after 2 cycles; a following row (0x0100,0x0300) last -> result=0x0300.
REQ-035 SHALL check reset mid-row: one pair (0x0100,0x0500), assert rst=0 for one cycle, then row (0x0100,0x0100) last -> all outputs 0 during reset, then result=0x0100.

Source files
------------

// File: rtl/euler_pkg.sv
// Shared constants and types for the euler fetch/buffer/MAC pipeline.
// Default fixed-point format is Q7.8 with 4 accumulator guard bits.
package euler_pkg;

  localparam int EULER_DATA_SIZE  = 16;
  localparam int EULER_FRAC_BITS  = 8;
  localparam int EULER_GUARD_BITS = 4;

  typedef enum logic {
    MAC_IDLE  = 1'b0,
    MAC_ACCUM = 1'b1
  } mac_state_e;

endpackage

// File: rtl/fixed_mul.sv
// Registered signed multiplier (stage 1 of the MAC): full-width product plus
// valid/last tags, all dropped by a synchronous clear.
module fixed_mul
  import euler_pkg::*;
#(
  parameter int DATA_SIZE = EULER_DATA_SIZE
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          valid_i,
  input  logic                          last_i,
  input  logic [DATA_SIZE-1:0]          a_i,
  input  logic [DATA_SIZE-1:0]          b_i,
  output logic signed [2*DATA_SIZE-1:0] prod_o,
  output logic                          valid_o,
  output logic                          last_o
);

  localparam int PROD_SIZE = 2 * DATA_SIZE;

  logic signed [PROD_SIZE-1:0] a_ext;
  logic signed [PROD_SIZE-1:0] b_ext;
  logic signed [PROD_SIZE-1:0] prod_d;
  logic signed [PROD_SIZE-1:0] prod_q;
  logic                        valid_q;
  logic                        last_q;

  // Operands are sign-extended up front so the product is exact at full width.
  assign a_ext  = {{DATA_SIZE{a_i[DATA_SIZE-1]}}, a_i};
  assign b_ext  = {{DATA_SIZE{b_i[DATA_SIZE-1]}}, b_i};
  assign prod_d = a_ext * b_ext;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (clear_i) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        prod_q <= prod_d;
        last_q <= last_i;
      end
    end
  end

  assign prod_o  = prod_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule

// File: rtl/mac_accum_stage.sv
// Row dot-product MAC: multiply (fixed_mul), accumulate, shift back to operand format.
// Define MAC_SATURATE_EN to clamp out-of-range results instead of wrapping.
module mac_accum_stage
  import euler_pkg::*;
#(
  parameter int DATA_SIZE  = EULER_DATA_SIZE,
  parameter int FRAC_BITS  = EULER_FRAC_BITS,
  parameter int GUARD_BITS = EULER_GUARD_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_a,
  input  logic [DATA_SIZE-1:0] in_b,
  input  logic                 row_last,
  input  logic                 flush,
  output logic [DATA_SIZE-1:0] result,
  output logic                 result_valid,
  output logic                 busy,
  output logic                 overflow
);

  localparam int PROD_SIZE = 2 * DATA_SIZE;
  localparam int ACC_SIZE  = 2 * DATA_SIZE + GUARD_BITS;

  logic                        accept;
  logic signed [PROD_SIZE-1:0] s1_prod;
  logic                        s1_valid;
  logic                        s1_last;

  mac_state_e state_q;
  mac_state_e state_d;

  logic signed [ACC_SIZE-1:0] acc_q;
  logic signed [ACC_SIZE-1:0] acc_d;
  logic signed [ACC_SIZE-1:0] prod_ext;
  logic signed [ACC_SIZE-1:0] sum;
  logic signed [ACC_SIZE-1:0] shifted;
  logic                       in_range;
  logic [DATA_SIZE-1:0]       res_word;
  logic [DATA_SIZE-1:0]       result_q;
  logic [DATA_SIZE-1:0]       result_d;
  logic                       result_valid_q;
  logic                       result_valid_d;
  logic                       overflow_q;
  logic                       overflow_d;

  // Flush wins over a coincident input pair.
  assign accept = in_valid & ~flush;

  fixed_mul #(
    .DATA_SIZE(DATA_SIZE)
  ) u_fixed_mul (
    .clk_i  (clk),
    .rst_ni (rst),
    .clear_i(flush),
    .valid_i(accept),
    .last_i (row_last),
    .a_i    (in_a),
    .b_i    (in_b),
    .prod_o (s1_prod),
    .valid_o(s1_valid),
    .last_o (s1_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MAC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MAC_IDLE:  if (accept && !row_last) state_d = MAC_ACCUM;
      MAC_ACCUM: if (flush || (accept && row_last)) state_d = MAC_IDLE;
      default:   state_d = MAC_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == MAC_ACCUM) | s1_valid | result_valid_q;
  end

  assign prod_ext = {{GUARD_BITS{s1_prod[PROD_SIZE-1]}}, s1_prod};
  assign sum      = acc_q + prod_ext;
  assign shifted  = sum >>> FRAC_BITS;
  // Representable iff every bit from the result sign upward agrees.
  assign in_range = (&shifted[ACC_SIZE-1:DATA_SIZE-1]) | ~(|shifted[ACC_SIZE-1:DATA_SIZE-1]);

`ifdef MAC_SATURATE_EN
  localparam logic [DATA_SIZE-1:0] SAT_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic [DATA_SIZE-1:0] SAT_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

  assign res_word = in_range ? shifted[DATA_SIZE-1:0]
                             : (shifted[ACC_SIZE-1] ? SAT_MIN : SAT_MAX);
`else
  assign res_word = shifted[DATA_SIZE-1:0];
`endif

  // Accumulator clears in the same cycle the result is taken: no bubble between rows.
  always_comb begin
    acc_d          = acc_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    overflow_d     = overflow_q;
    if (flush) begin
      acc_d = '0;
    end else if (s1_valid) begin
      if (s1_last) begin
        acc_d          = '0;
        result_d       = res_word;
        result_valid_d = 1'b1;
        if (!in_range) overflow_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_mac_accum_stage.sv
// Scoreboard bench for mac_accum_stage: directed rows push expected results,
// a negedge monitor pops and checks value and arrival cycle.
module tb_mac_accum_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        row_last;
  logic        flush;
  logic [15:0] result;
  logic        result_valid;
  logic        busy;
  logic        overflow;

  typedef struct {
    logic [15:0] val;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc;
  int   total;
  int   bad;

  mac_accum_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_a        (in_a),
    .in_b        (in_b),
    .row_last    (row_last),
    .flush       (flush),
    .result      (result),
    .result_valid(result_valid),
    .busy        (busy),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: %h (cycle %0d)", name, act, cyc);
    end
  endtask

  // One pair per call; the result of a row_last pair appears two edges later.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last,
                      input logic [15:0] exp_val);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    row_last = last;
    flush    = 1'b0;
    if (last) begin
      e.val = exp_val;
      e.cyc = cyc + 2;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      row_last = 1'b0;
      flush    = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst && result_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got=%h want=none (cycle %0d)", result, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("result_value", result, mon_e.val);
        chk("result_cycle", 16'(cyc), 16'(mon_e.cyc));
      end
    end
  end

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    row_last = 1'b0;
    flush    = 1'b0;

    #3;
    chk("reset_result", result, 16'h0000);
    chk("reset_valid", {15'd0, result_valid}, 16'h0000);
    chk("reset_busy", {15'd0, busy}, 16'h0000);
    chk("reset_overflow", {15'd0, overflow}, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Three-pair row.
    send(16'h0100, 16'h0200, 1'b0, 16'h0000);
    send(16'h0080, 16'h0100, 1'b0, 16'h0000);
    send(16'h0100, 16'hFF00, 1'b1, 16'h0180);
    idle(4);
    chk("row3_overflow", {15'd0, overflow}, 16'h0000);

    // Back-to-back single-pair rows.
    send(16'h0100, 16'h0100, 1'b1, 16'h0100);
    send(16'h0200, 16'h0100, 1'b1, 16'h0200);
    idle(4);
    chk("b2b_busy_idle", {15'd0, busy}, 16'h0000);

    // Gap in the middle of a row leaves the accumulator alone.
    send(16'h0200, 16'h0100, 1'b0, 16'h0000);
    idle(3);
    chk("gap_busy", {15'd0, busy}, 16'h0001);
    send(16'h0100, 16'h0100, 1'b1, 16'h0300);
    idle(4);

    // Overflowing single-pair row.
`ifdef MAC_SATURATE_EN
    send(16'h7F00, 16'h7F00, 1'b1, 16'h7FFF);
`else
    send(16'h7F00, 16'h7F00, 1'b1, 16'h0100);
`endif
    idle(4);
    chk("ovf_sticky", {15'd0, overflow}, 16'h0001);

    // Flush with a coincident valid pair drops everything.
    send(16'h0100, 16'h0100, 1'b0, 16'h0000);
    send(16'h0200, 16'h0200, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = 16'h0400;
    in_b     = 16'h0400;
    row_last = 1'b1;
    flush    = 1'b1;
    idle(2);
    chk("flush_busy", {15'd0, busy}, 16'h0000);
    chk("flush_keeps_ovf", {15'd0, overflow}, 16'h0001);
    idle(3);
    send(16'h0100, 16'h0300, 1'b1, 16'h0300);
    idle(4);

    // Reset in the middle of a row.
    send(16'h0100, 16'h0500, 1'b0, 16'h0000);
    idle(1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_result", result, 16'h0000);
    chk("midrst_valid", {15'd0, result_valid}, 16'h0000);
    chk("midrst_busy", {15'd0, busy}, 16'h0000);
    chk("midrst_overflow", {15'd0, overflow}, 16'h0000);
    @(posedge clk);
    #1 rst = 1'b1;
    send(16'h0100, 16'h0100, 1'b1, 16'h0100);
    idle(1);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
